// File: rtl/pdn_link_buffer_if.sv
// Neighbour-link valid/ready flit handshake feeding a pdn ingress buffer.
interface pdn_link_buffer_if;
  logic       in_valid;
  logic [9:0] in_flit;
  logic       in_ready;

  modport master (output in_valid, output in_flit, input in_ready);
  modport slave  (input in_valid, input in_flit, output in_ready);
endinterface

// File: rtl/pdn_link_buffer.sv
// Per-direction ingress FIFO in front of a pdn router input; emits one registered
// flit per cycle, with 10'h000 as the idle code.
module pdn_link_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  pdn_link_buffer_if.slave     link,
  input  logic                 out_hold,
  output logic [9:0]           out_flit,
  output logic [AW:0]          occupancy,
  output logic                 err_idle
);

  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [9:0]  IDLE     = 10'h000;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [9:0]    out_flit_q, out_flit_d;
  logic          err_idle_q, err_idle_d;

  logic accept, write_en, pop;

  assign link.in_ready = (occ_q != FULL_OCC) && !rst;
  assign accept        = link.in_valid && link.in_ready;
  // The idle code completes the handshake but never enters the queue.
  assign write_en      = accept && (link.in_flit != IDLE);
  // Pop decisions use registered occupancy, so a flit written this edge is not forwarded.
  assign pop           = !out_hold && (occ_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    out_flit_d = out_flit_q;
    err_idle_d = err_idle_q;

    if (write_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (accept && (link.in_flit == IDLE)) err_idle_d = 1'b1;

    if (!out_hold) begin
      if (pop) begin
        out_flit_d = mem[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + 1'b1;
      end else begin
        out_flit_d = IDLE;
      end
    end

    case ({write_en, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage carries no reset so it maps onto RAM; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (write_en) mem[wr_ptr_q] <= link.in_flit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      out_flit_q <= IDLE;
      err_idle_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      out_flit_q <= out_flit_d;
      err_idle_q <= err_idle_d;
    end
  end

  assign out_flit  = out_flit_q;
  assign occupancy = occ_q;
  assign err_idle  = err_idle_q;

endmodule

// File: tb/tb_pdn_link_buffer.sv
// Directed bench for pdn_link_buffer: reset, latency, fill, streaming wrap,
// idle-code error and mid-operation reset.
module tb_pdn_link_buffer;
  logic       clk = 1'b0;
  logic       rst;
  logic       out_hold;
  logic [9:0] out_flit;
  logic [2:0] occupancy;
  logic       err_idle;

  int checks = 0;
  int errors = 0;

  pdn_link_buffer_if link ();

  pdn_link_buffer #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .link      (link.slave),
    .out_hold  (out_hold),
    .out_flit  (out_flit),
    .occupancy (occupancy),
    .err_idle  (err_idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-12s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    // 1: reset held 3 cycles with in_valid asserted
    rst = 1'b1; out_hold = 1'b0;
    link.in_valid = 1'b1; link.in_flit = 10'h3FF;
    #1;
    chk("rst_ready0", 32'(link.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", 32'(link.in_ready), 32'd0);
      chk("rst_occ",   32'(occupancy),     32'd0);
      chk("rst_out",   32'(out_flit),      32'h000);
    end
    rst = 1'b0; link.in_valid = 1'b0;
    #1;
    chk("post_ready", 32'(link.in_ready), 32'd1);
    chk("post_err",   32'(err_idle),      32'd0);

    // 2: single flit, 2-edge latency, one-cycle pulse
    link.in_valid = 1'b1; link.in_flit = 10'h2A5;
    tick();
    link.in_valid = 1'b0;
    chk("s_out1", 32'(out_flit),  32'h000);
    chk("s_occ1", 32'(occupancy), 32'd1);
    tick();
    chk("s_out2", 32'(out_flit),  32'h2A5);
    chk("s_occ2", 32'(occupancy), 32'd0);
    tick();
    chk("s_out3", 32'(out_flit),  32'h000);

    // 3: fill under hold, 5th flit refused
    out_hold = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      link.in_valid = 1'b1; link.in_flit = 10'(i);
      #1;
      chk("f_ready", 32'(link.in_ready), (i <= 4) ? 32'd1 : 32'd0);
      tick();
      chk("f_occ", 32'(occupancy), (i <= 4) ? 32'(i) : 32'd4);
      chk("f_out", 32'(out_flit),  32'h000);
    end
    link.in_valid = 1'b0; out_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("f_drain", 32'(out_flit),  32'(i));
      chk("f_docc",  32'(occupancy), 32'(4 - i));
    end
    tick();
    chk("f_idle", 32'(out_flit), 32'h000);

    // 4: 20 back-to-back flits across pointer wrap
    for (int i = 0; i < 20; i++) begin
      link.in_valid = 1'b1; link.in_flit = 10'(10'h100 + i);
      tick();
      chk("w_occ", 32'(occupancy), 32'd1);
      chk("w_out", 32'(out_flit),  (i == 0) ? 32'h000 : 32'(10'h100 + i - 1));
    end
    link.in_valid = 1'b0;
    tick();
    chk("w_last", 32'(out_flit),  32'h113);
    chk("w_occ0", 32'(occupancy), 32'd0);
    tick();
    chk("w_idle", 32'(out_flit),  32'h000);

    // 5: idle code accepted, dropped, sticky error
    link.in_valid = 1'b1; link.in_flit = 10'h000;
    #1;
    chk("i_ready", 32'(link.in_ready), 32'd1);
    tick();
    link.in_valid = 1'b0;
    chk("i_err", 32'(err_idle),  32'd1);
    chk("i_occ", 32'(occupancy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("i_out",    32'(out_flit), 32'h000);
      chk("i_sticky", 32'(err_idle), 32'd1);
    end

    // 6: mid-operation reset with a held output and 3 queued flits
    link.in_valid = 1'b1; link.in_flit = 10'h3A0;
    tick();
    link.in_valid = 1'b0;
    tick();
    chk("m_out", 32'(out_flit), 32'h3A0);
    out_hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      link.in_valid = 1'b1; link.in_flit = 10'(10'h3A0 + i);
      tick();
    end
    link.in_valid = 1'b0;
    chk("m_occ3", 32'(occupancy), 32'd3);
    chk("m_hold", 32'(out_flit),  32'h3A0);
    rst = 1'b1;
    tick();
    chk("m_occ",   32'(occupancy),     32'd0);
    chk("m_rout",  32'(out_flit),      32'h000);
    chk("m_err",   32'(err_idle),      32'd0);
    chk("m_ready", 32'(link.in_ready), 32'd0);
    rst = 1'b0; out_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("m_gone", 32'(out_flit),  32'h000);
      chk("m_empt", 32'(occupancy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
